// File: rtl/spi_master.sv
// SPI master: shifts one byte out on mosi_o and one byte in on miso_i per
// handshake, LSB first. sclk_o idles high; data launches on the sclk_o rising
// edge and is captured on the falling edge. One transaction is chip-select
// setup, 8 low/7 high sclk half-periods, a hold, and an inter-byte gap.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   tx_data_i/tx_valid_i  byte to send and request (taken when tx_ready_o=1)
//   tx_ready_o            high only while idle
//   rx_data_o/rx_valid_o  received byte and one-cycle completion pulse
//   busy_o                high whenever not idle
//   sclk_o/mosi_o/cs_n_o  SPI outputs (all registered)
//   miso_i                SPI data in
module spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       busy_o,
  output logic       sclk_o,
  output logic       mosi_o,
  input  logic       miso_i,
  output logic       cs_n_o
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned BIT_W = 3;
  localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(7);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_LOW, ST_HIGH, ST_HOLD, ST_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic [7:0]       rx_data_d;
  logic             rx_valid_d, busy_d, ready_d, sclk_d, mosi_d, cs_n_d;
  logic             hs, tc;

  // tx_ready_o is registered and mirrors the IDLE state
  assign hs = tx_valid_i & tx_ready_o;
  assign tc = (cnt_q == CNT_TC);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; every timed state lasts CLK_DIV cycles
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (hs) state_d = ST_SETUP;
      ST_SETUP: if (tc) state_d = ST_LOW;
      ST_LOW:   if (tc) state_d = (bit_q == BIT_LAST) ? ST_HOLD : ST_HIGH;
      ST_HIGH:  if (tc) state_d = ST_LOW;
      ST_HOLD:  if (tc) state_d = ST_GAP;
      ST_GAP:   if (tc) state_d = ST_IDLE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Next values of the datapath and of the registered outputs
  always_comb begin
    cnt_d      = (state_q == ST_IDLE || tc) ? '0 : cnt_q + CNT_W'(1);
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_o;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_o;
    mosi_d     = mosi_o;
    cs_n_d     = cs_n_o;
    unique case (state_q)
      ST_IDLE: begin
        if (hs) begin
          cs_n_d  = 1'b0;
          tx_sh_d = tx_data_i;
          mosi_d  = tx_data_i[0];
          bit_d   = '0;
        end
      end
      // falling sclk edge: capture miso_i on the same clk edge
      ST_SETUP, ST_HIGH: begin
        if (tc) begin
          sclk_d  = 1'b0;
          rx_sh_d = {miso_i, rx_sh_q[7:1]};
        end
      end
      // rising sclk edge: launch the next bit; bit counter stops at 7
      ST_LOW: begin
        if (tc) begin
          sclk_d = 1'b1;
          if (bit_q != BIT_LAST) begin
            bit_d   = bit_q + BIT_W'(1);
            tx_sh_d = {1'b0, tx_sh_q[7:1]};
            mosi_d  = tx_sh_q[1];
          end
        end
      end
      ST_HOLD: begin
        if (tc) begin
          cs_n_d     = 1'b1;
          mosi_d     = 1'b0;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      busy_o     <= 1'b0;
      tx_ready_o <= 1'b1;
      sclk_o     <= 1'b1;
      mosi_o     <= 1'b0;
      cs_n_o     <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_o  <= rx_data_d;
      rx_valid_o <= rx_valid_d;
      busy_o     <= busy_d;
      tx_ready_o <= ready_d;
      sclk_o     <= sclk_d;
      mosi_o     <= mosi_d;
      cs_n_o     <= cs_n_d;
    end
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4, SCLK half-period in clk cycles; legal range 1..255.
REQ-002 clk  input  1  sole clock; all logic on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 tx_data_i  input  8  byte to transmit; sampled only on handshake.
REQ-005 tx_valid_i  input  1  transmit request; handshake is tx_valid_i & tx_ready_o at a clk edge.
REQ-006 tx_ready_o  output  1  high only in IDLE.
REQ-007 rx_data_o  output  8  byte received on miso_i; holds until the next transaction completes.
REQ-008 rx_valid_o  output  1  one-cycle pulse on transaction completion.
REQ-009 busy_o  output  1  high in every state except IDLE.
REQ-010 sclk_o  output  1  SPI clock; idles high.
REQ-011 mosi_o  output  1  SPI data out, LSB first.
REQ-012 miso_i  input  1  SPI data in, LSB first.
REQ-013 cs_n_o  output  1  active-low chip select.
REQ-014 All outputs shall be registered.

Function
REQ-015 The FSM shall have states IDLE, SETUP, LOW, HIGH, HOLD, GAP.
REQ-016 IDLE: cs_n_o=1, sclk_o=1, mosi_o=0; on handshake, latch tx_data_i into the shift register and enter SETUP.
REQ-017 SETUP (CLK_DIV cycles): cs_n_o=0, sclk_o=1, mosi_o=bit 0.
REQ-018 On leaving SETUP or HIGH, sclk_o shall go 0 (falling edge) and the FSM shall enter LOW.
REQ-019 On each 1->0 transition of sclk_o, the FSM shall capture miso_i into the receive shift register (LSB first).
REQ-020 LOW (CLK_DIV cycles): on exit, sclk_o shall go 1; if fewer than 8 bits are done, mosi_o shall advance to the next bit on the same edge and the FSM shall enter HIGH; after the 8th bit it shall enter HOLD.
REQ-021 HIGH (CLK_DIV cycles): sclk_o=1 and mosi_o stable.
REQ-022 HOLD (CLK_DIV cycles): cs_n_o=0, sclk_o=1.
REQ-023 On HOLD exit: cs_n_o=1, mosi_o=0, rx_data_o updated from the shift register, rx_valid_o pulsed for exactly that cycle, and the FSM enters GAP.
REQ-024 GAP (CLK_DIV cycles): cs_n_o=1, then IDLE.
REQ-025 Timing totals per transaction: cs_n_o low for exactly 17*CLK_DIV cycles; exactly 8 falling SCLK edges; no SCLK edge while cs_n_o=1.
REQ-026 With tx_valid_i held high, cs_n_o between bytes shall be high for exactly CLK_DIV+1 cycles.
REQ-027 Handshake rules: tx_valid_i/tx_data_i are ignored outside IDLE; tx_data_i changes after the handshake shall not affect the transaction in progress.
REQ-028 The half-period counter shall be wide enough for 255; its terminal count is CLK_DIV-1; the bit counter is 3 bits and saturates at transaction end, never wrapping into a ninth bit.
REQ-029 CLK_DIV=1 shall produce a 2-cycle SCLK period with otherwise identical sequencing.

Reset
REQ-030 rst_n low shall force, asynchronously: state IDLE, cs_n_o=1, sclk_o=1, mosi_o=0, rx_data_o=0x00, rx_valid_o=0, busy_o=0, all counters 0.
REQ-031 A reset mid-transaction shall abort it with no rx_valid_o pulse; the first handshake after rst_n rises shall start a full, fresh transaction.

Verification
REQ-032 CLK_DIV=4, send 0xA5, mosi_o looped to miso_i -> mosi_o at the 8 falling edges = 1,0,1,0,0,1,0,1; cs_n_o low 68 cycles; rx_data_o=0xA5 with one rx_valid_o pulse.
REQ-033 CLK_DIV=4, miso_i driven by a model returning 0x3C LSB-first -> rx_data_o=0x3C; drive 0x3C into the downstream SPI-to-GPIO slave on the same clk -> its 8-bit output = 0x3C.
REQ-034 tx_valid_i held high with 0x01 then 0x80 -> two transactions; cs_n_o high exactly 5 cycles between them; the second byte is received as 0x80.
REQ-035 CLK_DIV=1, send 0xFF -> sclk_o period 2 cycles, cs_n_o low 17 cycles, 8 falling edges.
REQ-036 rst_n pulsed low after the 3rd falling edge -> cs_n_o=1, sclk_o=1 immediately; no rx_valid_o; the next byte 0x5A completes normally with rx_data_o=0x5A in loopback.
REQ-037 tx_data_i changed to 0x00 one cycle after handshake of 0xC3 -> 0xC3 is transmitted unchanged.
